pwm_capture_mc: RTL and testbench

Multi-channel, parametrised PWM capture block for the Knight test benches and physics model. It is the synthesizable successor to the single-channel fixed-window inverse PWM. For each of NCH PWM inputs it recovers the high time and the period. It runs in one of two modes: a fixed-window mode, which keeps legacy behaviour, or an edge-locked mode, which measures arbitrary periods and flags stuck signals. The block sits between the motor-drive PWM outputs and any consumer of duty magnitudes: the physics model, scoreboards, or on-chip self-test.

---
 rtl/pwm_capture_mc_if.sv | 40 ++++
 rtl/pwm_capture_mc.sv | 191 +++++++++++++++++++
 tb/tb_pwm_capture_mc.sv | 334 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pwm_capture_mc_if.sv
// pwm_capture_mc_if
//   Bundles the PWM capture block's functional signals.
//   master : the environment (drives mode/pwm_in, observes results)
//   slave  : the capture block itself
//   Signals:
//     mode        0 = fixed window, 1 = edge-locked
//     pwm_in      raw asynchronous PWM inputs, one bit per channel
//     duty_out    captured high-cycle counts, channel k at [k*WIDTH +: WIDTH]
//     period_out  captured periods, same packing as duty_out
//     vld         one-cycle pulse per channel when duty/period update
//     stuck       per-channel level flag, no rising edge for MAX cycles
interface pwm_capture_mc_if #(
    parameter int unsigned NCH   = 4,
    parameter int unsigned WIDTH = 11
);
    logic                 mode;
    logic [NCH-1:0]       pwm_in;
    logic [NCH*WIDTH-1:0] duty_out;
    logic [NCH*WIDTH-1:0] period_out;
    logic [NCH-1:0]       vld;
    logic [NCH-1:0]       stuck;

    modport master (
        output mode,
        output pwm_in,
        input  duty_out,
        input  period_out,
        input  vld,
        input  stuck
    );

    modport slave (
        input  mode,
        input  pwm_in,
        output duty_out,
        output period_out,
        output vld,
        output stuck
    );
endinterface

// File: rtl/pwm_capture_mc.sv
// pwm_capture_mc
//   Multi-channel PWM capture. Recovers high time and period of NCH PWM
//   inputs, either over a fixed 2^WIDTH-cycle window (mode=0) or locked to
//   the rising edges of each channel (mode=1) with stuck-signal detection.
//   Ports:
//     clk    system clock
//     rst_n  asynchronous active-low reset, clears all state and outputs
//     bus    pwm_capture_mc_if slave modport (mode, pwm_in, duty_out,
//            period_out, vld, stuck)
module pwm_capture_mc #(
    parameter int unsigned NCH         = 4,
    parameter int unsigned WIDTH       = 11,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    pwm_capture_mc_if.slave   bus
);

    // Fewer than two synchronizer stages is never safe; clamp silently.
    localparam int unsigned SS = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
    localparam logic [WIDTH-1:0] MAX = '1;

    typedef enum logic {
        MODE_WINDOW = 1'b0,
        MODE_EDGE   = 1'b1
    } mode_e;

    // Per-channel edge-mode state: waiting for the arming rise, armed and
    // capturing on every rise, or declared stuck.
    typedef enum logic [1:0] {
        CH_UNARMED = 2'd0,
        CH_ARMED   = 2'd1,
        CH_STUCK   = 2'd2
    } ch_state_e;

    // ------------------------------------------------------------------
    // Input conditioning
    // ------------------------------------------------------------------
    logic [NCH-1:0] sync_q [SS];
    logic [NCH-1:0] s_d_q;
    logic [NCH-1:0] s;
    logic [NCH-1:0] rise;

    assign s    = sync_q[SS-1];
    assign rise = s & ~s_d_q;

    // ------------------------------------------------------------------
    // Mode tracking
    // ------------------------------------------------------------------
    mode_e mode_q;
    mode_e mode_prev_q;
    logic  mode_chg;

    // A change is seen one cycle after the registered mode updates, so the
    // whole datapath restarts cleanly under the new mode.
    assign mode_chg = (mode_q != mode_prev_q);

    // ------------------------------------------------------------------
    // Counters and captured results
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] wcnt_q;
    logic [WIDTH-1:0] h_q      [NCH];
    logic [WIDTH-1:0] p_q      [NCH];
    ch_state_e        ch_st_q  [NCH];
    logic [WIDTH-1:0] duty_q   [NCH];
    logic [WIDTH-1:0] period_q [NCH];
    logic [NCH-1:0]   vld_q;
    logic [NCH-1:0]   stuck_q;

    // Saturating increments used by both modes.
    logic [WIDTH-1:0] h_inc [NCH];
    logic [WIDTH-1:0] p_inc [NCH];

    always_comb begin
        for (int unsigned ch = 0; ch < NCH; ch++) begin
            h_inc[ch] = (h_q[ch] == MAX) ? MAX : (h_q[ch] + {{(WIDTH-1){1'b0}}, s[ch]});
            p_inc[ch] = (p_q[ch] == MAX) ? MAX : (p_q[ch] + WIDTH'(1));
        end
    end

    // ------------------------------------------------------------------
    // Synchronizer and mode registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < SS; i++) begin
                sync_q[i] <= '0;
            end
            s_d_q       <= '0;
            mode_q      <= MODE_WINDOW;
            mode_prev_q <= MODE_WINDOW;
        end else begin
            sync_q[0] <= bus.pwm_in;
            for (int unsigned i = 1; i < SS; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            s_d_q       <= s;
            mode_q      <= mode_e'(bus.mode);
            mode_prev_q <= mode_q;
        end
    end

    // ------------------------------------------------------------------
    // Capture datapath and per-channel state
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wcnt_q  <= '0;
            vld_q   <= '0;
            stuck_q <= '0;
            for (int unsigned ch = 0; ch < NCH; ch++) begin
                h_q[ch]      <= '0;
                p_q[ch]      <= '0;
                ch_st_q[ch]  <= CH_UNARMED;
                duty_q[ch]   <= '0;
                period_q[ch] <= '0;
            end
        end else begin
            vld_q <= '0;

            if (mode_chg) begin
                // Restart everything under the new mode; results are held.
                wcnt_q  <= '0;
                stuck_q <= '0;
                for (int unsigned ch = 0; ch < NCH; ch++) begin
                    h_q[ch]     <= '0;
                    p_q[ch]     <= '0;
                    ch_st_q[ch] <= CH_UNARMED;
                end
            end else if (mode_q == MODE_WINDOW) begin
                wcnt_q  <= wcnt_q + WIDTH'(1);
                stuck_q <= '0;
                for (int unsigned ch = 0; ch < NCH; ch++) begin
                    if (wcnt_q == MAX) begin
                        // The level during the MAX cycle itself is dropped.
                        duty_q[ch]   <= h_q[ch];
                        period_q[ch] <= MAX;
                        h_q[ch]      <= '0;
                        vld_q[ch]    <= 1'b1;
                    end else begin
                        h_q[ch] <= h_inc[ch];
                    end
                end
            end else begin
                wcnt_q <= '0;
                for (int unsigned ch = 0; ch < NCH; ch++) begin
                    if (rise[ch]) begin
                        // A rise always wins over the stuck check.
                        p_q[ch] <= WIDTH'(1);
                        h_q[ch] <= WIDTH'(1);
                        if (ch_st_q[ch] == CH_ARMED) begin
                            duty_q[ch]   <= h_q[ch];
                            period_q[ch] <= p_q[ch];
                            vld_q[ch]    <= 1'b1;
                        end else begin
                            // Unarmed or stuck: this rise only (re)arms.
                            ch_st_q[ch] <= CH_ARMED;
                            stuck_q[ch] <= 1'b0;
                        end
                    end else if (p_q[ch] == MAX) begin
                        // p holds at MAX; report the stuck level only once.
                        h_q[ch] <= h_inc[ch];
                        if (ch_st_q[ch] != CH_STUCK) begin
                            ch_st_q[ch]  <= CH_STUCK;
                            stuck_q[ch]  <= 1'b1;
                            duty_q[ch]   <= s[ch] ? MAX : '0;
                            period_q[ch] <= MAX;
                            vld_q[ch]    <= 1'b1;
                        end
                    end else begin
                        p_q[ch] <= p_inc[ch];
                        h_q[ch] <= h_inc[ch];
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Output packing
    // ------------------------------------------------------------------
    for (genvar g = 0; g < NCH; g++) begin : g_out
        assign bus.duty_out[g*WIDTH +: WIDTH]   = duty_q[g];
        assign bus.period_out[g*WIDTH +: WIDTH] = period_q[g];
    end

    assign bus.vld   = vld_q;
    assign bus.stuck = stuck_q;

endmodule

// File: tb/tb_pwm_capture_mc.sv
// tb_pwm_capture_mc
//   Directed scenarios with randomized PWM shapes, checked every cycle
//   against a timestamp/sum based reference model, plus scenario checks.
module tb_pwm_capture_mc;

    localparam int unsigned NCH   = 4;
    localparam int unsigned WIDTH = 11;
    localparam int          SS    = 2;
    localparam int          MAXV  = (1 << WIDTH) - 1;
    localparam int          HIST  = 40000;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    pwm_capture_mc_if #(.NCH(NCH), .WIDTH(WIDTH)) bus ();

    pwm_capture_mc #(.NCH(NCH), .WIDTH(WIDTH), .SYNC_STAGES(SS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Stimulus generators: kind 0 = low, 1 = high, 2 = PWM.
    int gen_kind [NCH];
    int gen_per  [NCH];
    int gen_hi   [NCH];
    int gen_ph   [NCH];
    logic cur_mode;

    // Reference model: raw input/mode history indexed by cycle since reset.
    bit [NCH-1:0] xh [HIST];
    bit           mh [HIST];
    int k;
    int base  [NCH];
    int wbase;
    bit armed [NCH];
    bit stk   [NCH];
    int e_duty[NCH];
    int e_per [NCH];
    bit e_vld [NCH];

    // Scenario bookkeeping.
    int vld_cnt   [NCH];
    int cap_duty  [NCH];
    int cap_per   [NCH];
    int last_raw  [NCH];
    int last_vld_k[NCH];
    int rise_cnt  [NCH];
    int raw_2nd   [NCH];
    int first_vld [NCH];
    int all4_cnt;

    task automatic chk(input string tag, input int ch, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s ch%0d: got %0d expected %0d", tag, ch, obs, exp);
        end
    endtask

    // Synchronized level seen by the block in cycle c.
    function automatic bit sv(input int ch, input int c);
        int r;
        r = c - SS;
        if (r < 0) return 1'b0;
        return xh[r][ch];
    endfunction

    function automatic bit ms(input int c);
        if (c < 0) return 1'b0;
        return mh[c];
    endfunction

    // Number of synchronized-high cycles in [a, b).
    function automatic int hsum(input int ch, input int a, input int b);
        int acc;
        acc = 0;
        for (int c = a; c < b; c++) acc += sv(ch, c);
        return acc;
    endfunction

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic model_reset();
        k     = 0;
        wbase = 0;
        for (int ch = 0; ch < NCH; ch++) begin
            base[ch] = 0; armed[ch] = 0; stk[ch] = 0;
            e_duty[ch] = 0; e_per[ch] = 0; e_vld[ch] = 0;
        end
    endtask

    // Outcome of cycle k, as visible just after clock edge k.
    task automatic model_step();
        bit chg, edge_m, rise;
        int pk;
        chg    = (ms(k-1) != ms(k-2));
        edge_m = ms(k-1);
        for (int ch = 0; ch < NCH; ch++) e_vld[ch] = 0;
        if (chg) begin
            wbase = k + 1;
            for (int ch = 0; ch < NCH; ch++) begin
                base[ch] = k + 1; armed[ch] = 0; stk[ch] = 0;
            end
        end else if (!edge_m) begin
            if (((k - wbase) % (MAXV + 1)) == MAXV) begin
                for (int ch = 0; ch < NCH; ch++) begin
                    e_duty[ch] = hsum(ch, k - MAXV, k);
                    e_per[ch]  = MAXV;
                    e_vld[ch]  = 1;
                end
            end
        end else begin
            for (int ch = 0; ch < NCH; ch++) begin
                rise = sv(ch, k) && !sv(ch, k-1);
                pk   = imin(k - base[ch], MAXV);
                if (rise) begin
                    if (stk[ch]) begin
                        stk[ch] = 0; armed[ch] = 1;
                    end else if (armed[ch]) begin
                        e_duty[ch] = imin(hsum(ch, base[ch], k), MAXV);
                        e_per[ch]  = pk;
                        e_vld[ch]  = 1;
                    end else begin
                        armed[ch] = 1;
                    end
                    base[ch] = k;
                end else if (pk == MAXV && !stk[ch]) begin
                    stk[ch]    = 1;
                    armed[ch]  = 0;
                    e_duty[ch] = sv(ch, k) ? MAXV : 0;
                    e_per[ch]  = MAXV;
                    e_vld[ch]  = 1;
                end
            end
        end
    endtask

    task automatic check_all();
        for (int ch = 0; ch < NCH; ch++) begin
            chk("vld",    ch, 64'(bus.vld[ch]),   64'(e_vld[ch]));
            chk("stuck",  ch, 64'(bus.stuck[ch]), 64'(stk[ch]));
            chk("duty",   ch, 64'(bus.duty_out[ch*WIDTH +: WIDTH]),   64'(e_duty[ch]));
            chk("period", ch, 64'(bus.period_out[ch*WIDTH +: WIDTH]), 64'(e_per[ch]));
        end
    endtask

    task automatic clear_track();
        all4_cnt = 0;
        for (int ch = 0; ch < NCH; ch++) begin
            vld_cnt[ch] = 0; cap_duty[ch] = -1; cap_per[ch] = -1;
            rise_cnt[ch] = 0; raw_2nd[ch] = -1; first_vld[ch] = -1;
        end
    endtask

    task automatic run(input int n);
        logic [NCH-1:0] xv;
        for (int i = 0; i < n; i++) begin
            for (int ch = 0; ch < NCH; ch++) begin
                case (gen_kind[ch])
                    0:       xv[ch] = 1'b0;
                    1:       xv[ch] = 1'b1;
                    default: xv[ch] = ((k + gen_ph[ch]) % gen_per[ch]) < gen_hi[ch];
                endcase
            end
            bus.pwm_in = xv;
            bus.mode   = cur_mode;
            @(posedge clk);
            xh[k] = bus.pwm_in;
            mh[k] = bus.mode;
            model_step();
            #1;
            check_all();
            for (int ch = 0; ch < NCH; ch++) begin
                if (xh[k][ch] && (k == 0 || !xh[k-1][ch])) begin
                    last_raw[ch] = k;
                    rise_cnt[ch]++;
                    if (rise_cnt[ch] == 2) raw_2nd[ch] = k;
                end
                if (bus.vld[ch]) begin
                    vld_cnt[ch]++;
                    cap_duty[ch]   = int'(bus.duty_out[ch*WIDTH +: WIDTH]);
                    cap_per[ch]    = int'(bus.period_out[ch*WIDTH +: WIDTH]);
                    last_vld_k[ch] = k;
                    if (first_vld[ch] < 0) first_vld[ch] = k;
                end
            end
            if (bus.vld == '1) all4_cnt++;
            k++;
        end
    endtask

    int guard;
    int per_tab [NCH];

    initial begin
        for (int ch = 0; ch < NCH; ch++) begin
            gen_kind[ch] = 0; gen_per[ch] = 1; gen_hi[ch] = 0; gen_ph[ch] = 0;
            last_raw[ch] = 0; last_vld_k[ch] = 0;
        end
        cur_mode   = 1'b0;
        bus.mode   = 1'b0;
        bus.pwm_in = '0;
        rst_n      = 1'b0;
        model_reset();
        clear_track();
        #1;
        chk("rst_duty",   0, 64'(bus.duty_out),   64'd0);
        chk("rst_period", 0, 64'(bus.period_out), 64'd0);
        chk("rst_vld",    0, 64'(bus.vld),        64'd0);
        chk("rst_stuck",  0, 64'(bus.stuck),      64'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Window mode: ch0 high, ch1 low, ch2/ch3 random PWM.
        gen_kind[0] = 1; gen_kind[1] = 0;
        for (int ch = 2; ch < NCH; ch++) begin
            gen_kind[ch] = 2;
            gen_per[ch]  = $urandom_range(50, 500);
            gen_hi[ch]   = $urandom_range(1, gen_per[ch] - 1);
            gen_ph[ch]   = $urandom_range(0, gen_per[ch] - 1);
        end
        run(4100);
        chk("win_duty_hi",  0, 64'(cap_duty[0]), 64'(MAXV));
        chk("win_duty_lo",  1, 64'(cap_duty[1]), 64'd0);
        chk("win_per",      0, 64'(cap_per[0]),  64'(MAXV));
        chk("win_per",      1, 64'(cap_per[1]),  64'(MAXV));
        chk("win_all4_cnt", 0, 64'(all4_cnt),    64'd2);

        // Edge mode: ch2 1000/250, ch3 600/200 then held low.
        cur_mode = 1'b1;
        clear_track();
        gen_kind[0] = 0; gen_kind[1] = 0;
        gen_kind[2] = 2; gen_per[2] = 1000; gen_hi[2] = 250; gen_ph[2] = $urandom_range(0, 999);
        gen_kind[3] = 2; gen_per[3] = 600;  gen_hi[3] = 200; gen_ph[3] = 0;
        run(2500);
        guard = 0;
        while ((k % 600) != 300 && guard < 700) begin
            run(1);
            guard++;
        end
        chk("bound_phase", 3, 64'(guard < 700), 64'd1);
        chk("ch3_good_caps", 3, 64'(vld_cnt[3] >= 3), 64'd1);
        gen_kind[3] = 0;
        vld_cnt[3]  = 0;
        run(1800);
        chk("stuck_lo_flag", 3, 64'(bus.stuck[3]), 64'd1);
        chk("stuck_lo_duty", 3, 64'(cap_duty[3]),  64'd0);
        chk("stuck_lo_per",  3, 64'(cap_per[3]),   64'(MAXV));
        chk("stuck_lo_vlds", 3, 64'(vld_cnt[3]),   64'd1);
        chk("stuck_lo_time", 3, 64'(last_vld_k[3] - last_raw[3]), 64'(SS + MAXV));
        // Resume ch3 in its low phase: first rise only clears stuck.
        gen_kind[3] = 2;
        vld_cnt[3]  = 0;
        run(310);
        chk("unstuck_flag", 3, 64'(bus.stuck[3]), 64'd0);
        chk("unstuck_novld", 3, 64'(vld_cnt[3]), 64'd0);
        run(620);
        chk("recap_vlds", 3, 64'(vld_cnt[3]), 64'd1);
        chk("recap_duty", 3, 64'(cap_duty[3]), 64'd200);
        chk("recap_per",  3, 64'(cap_per[3]),  64'd600);
        chk("edge_duty",  2, 64'(cap_duty[2]), 64'd250);
        chk("edge_per",   2, 64'(cap_per[2]),  64'd1000);
        // Clock edges from the one sampling the raw rise to the one
        // producing vld, inclusive.
        chk("edge_latency", 2, 64'(last_vld_k[2] - last_raw[2] + 1), 64'(SS + 1));

        // Stuck high on ch1 (currently stuck low).
        gen_kind[1] = 1;
        vld_cnt[1]  = 0;
        run(5000);
        chk("stuck_hi_flag", 1, 64'(bus.stuck[1]), 64'd1);
        chk("stuck_hi_vlds", 1, 64'(vld_cnt[1]),   64'd1);
        chk("stuck_hi_duty", 1, 64'(cap_duty[1]),  64'(MAXV));
        chk("stuck_hi_per",  1, 64'(cap_per[1]),   64'(MAXV));

        // Independent periods with mode toggles mid-period.
        per_tab[0] = 300; per_tab[1] = 700; per_tab[2] = 1200; per_tab[3] = 1500;
        for (int ch = 0; ch < NCH; ch++) begin
            gen_kind[ch] = 2;
            gen_per[ch]  = per_tab[ch];
            gen_hi[ch]   = $urandom_range(per_tab[ch] / 5, (4 * per_tab[ch]) / 5);
            gen_ph[ch]   = $urandom_range(0, per_tab[ch] - 1);
        end
        run(4000);
        cur_mode = 1'b0;
        run(2);
        chk("sw_to_win_novld", 0, 64'(bus.vld), 64'd0);
        run($urandom_range(100, 600));
        cur_mode = 1'b1;
        run(2);
        chk("sw_to_edge_novld", 0, 64'(bus.vld), 64'd0);
        clear_track();
        run(4000);
        for (int ch = 0; ch < NCH; ch++) begin
            chk("indep_seen", ch, 64'(vld_cnt[ch] > 0), 64'd1);
            chk("indep_per",  ch, 64'(cap_per[ch]),  64'(per_tab[ch]));
            chk("indep_duty", ch, 64'(cap_duty[ch]), 64'(gen_hi[ch]));
        end

        // Reset during a high phase of ch0.
        gen_hi[0] = 120;
        guard = 0;
        while (bus.pwm_in[0] !== 1'b1 && guard < 400) begin
            run(1);
            guard++;
        end
        chk("bound_high", 0, 64'(guard < 400), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_duty",   0, 64'(bus.duty_out),   64'd0);
        chk("mid_rst_period", 0, 64'(bus.period_out), 64'd0);
        chk("mid_rst_vld",    0, 64'(bus.vld),        64'd0);
        chk("mid_rst_stuck",  0, 64'(bus.stuck),      64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();
        clear_track();
        run(1000);
        chk("post_rst_2nd_rise", 0, 64'(first_vld[0] - raw_2nd[0]), 64'(SS));
        chk("post_rst_per",      0, 64'(cap_per[0]),  64'd300);
        chk("post_rst_duty",     0, 64'(cap_duty[0]), 64'd120);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
